multicycle_ctrl: RTL and testbench

Multi-cycle control FSM for the MIPS core: sequences a single shared ALU and memory port through fetch, decode, execute, memory and write-back steps. It drives the PC update (PC+4, branch target, or jump target with `beq`/`bne` resolution) and every datapath enable. It stalls on a memory ready handshake. It sits between the instruction register/ALU flags and the datapath muxes, replacing per-instruction combinational control.

---
 rtl/multicycle_ctrl_pkg.sv | 65 ++++++
 rtl/multicycle_ctrl_if.sv | 10 +
 rtl/multicycle_ctrl_out_decode.sv | 85 ++++++++
 rtl/multicycle_ctrl.sv | 82 ++++++++
 tb/tb_multicycle_ctrl.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, FSM states,
// datapath mux selects and the bundled control word.
package mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_ALU_WB    = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11
  } state_t;

  localparam logic [1:0] PCSRC_SEQ = 2'd0;
  localparam logic [1:0] PCSRC_BR  = 2'd1;
  localparam logic [1:0] PCSRC_JMP = 2'd2;

  localparam logic [1:0] ALUB_RT     = 2'd0;
  localparam logic [1:0] ALUB_FOUR   = 2'd1;
  localparam logic [1:0] ALUB_IMM    = 2'd2;
  localparam logic [1:0] ALUB_IMM_SH = 2'd3;

  localparam logic [1:0] ALUOP_ADD   = 2'd0;
  localparam logic [1:0] ALUOP_SUB   = 2'd1;
  localparam logic [1:0] ALUOP_FUNCT = 2'd2;

  typedef struct packed {
    logic       pc_en;
    logic [1:0] pc_src;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_t;

  function automatic logic op_supported(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI: op_supported = 1'b1;
      default:                                               op_supported = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Memory port handshake between the controller and the shared memory.
interface multicycle_ctrl_if;
  logic mem_read;
  logic mem_write;
  logic iord;
  logic mem_ready;

  modport master (output mem_read, mem_write, iord, input mem_ready);
  modport slave  (input mem_read, mem_write, iord, output mem_ready);
endinterface

// File: rtl/multicycle_ctrl_out_decode.sv
// Combinational control-word decode from the current state; every enable is
// suppressed while the controller is held in reset.
module mc_out_decode
  import mc_pkg::*;
(
  input  state_t     state_i,
  input  logic [5:0] opcode_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  input  logic       active_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    if (active_i) begin
      case (state_i)
        S_FETCH: begin
          ctrl_o.mem_read  = 1'b1;
          ctrl_o.alu_src_b = ALUB_FOUR;
          ctrl_o.ir_write  = mem_ready_i;
          ctrl_o.pc_en     = mem_ready_i;
        end
        S_DECODE: begin
          ctrl_o.alu_src_b = ALUB_IMM_SH;
          if (!op_supported(opcode_i)) begin
            ctrl_o.illegal_op = 1'b1;
            ctrl_o.instr_done = 1'b1;
          end
        end
        S_MEM_ADDR: begin
          ctrl_o.alu_src_a = 1'b1;
          ctrl_o.alu_src_b = ALUB_IMM;
        end
        S_MEM_READ: begin
          ctrl_o.mem_read = 1'b1;
          ctrl_o.iord     = 1'b1;
        end
        S_MEM_WB: begin
          ctrl_o.reg_write  = 1'b1;
          ctrl_o.mem_to_reg = 1'b1;
          ctrl_o.instr_done = 1'b1;
        end
        S_MEM_WRITE: begin
          ctrl_o.mem_write  = 1'b1;
          ctrl_o.iord       = 1'b1;
          ctrl_o.instr_done = mem_ready_i;
        end
        S_R_EXEC: begin
          ctrl_o.alu_src_a = 1'b1;
          ctrl_o.alu_src_b = ALUB_RT;
          ctrl_o.alu_op    = ALUOP_FUNCT;
        end
        S_ALU_WB: begin
          ctrl_o.reg_write  = 1'b1;
          ctrl_o.reg_dst    = 1'b1;
          ctrl_o.instr_done = 1'b1;
        end
        S_BRANCH: begin
          // bne inverts the sense of the zero flag
          ctrl_o.alu_src_a  = 1'b1;
          ctrl_o.alu_op     = ALUOP_SUB;
          ctrl_o.pc_src     = PCSRC_BR;
          ctrl_o.pc_en      = zero_i ^ (opcode_i == OP_BNE);
          ctrl_o.instr_done = 1'b1;
        end
        S_JUMP: begin
          ctrl_o.pc_src     = PCSRC_JMP;
          ctrl_o.pc_en      = 1'b1;
          ctrl_o.instr_done = 1'b1;
        end
        S_ADDI_EXEC: begin
          ctrl_o.alu_src_a = 1'b1;
          ctrl_o.alu_src_b = ALUB_IMM;
        end
        S_ADDI_WB: begin
          ctrl_o.reg_write  = 1'b1;
          ctrl_o.instr_done = 1'b1;
        end
        default: ctrl_o = '0;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: state register and next-state logic, with the
// control word produced by mc_out_decode.
module multicycle_ctrl
  import mc_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode_i,
  input  logic               zero_i,
  multicycle_ctrl_if.master  mem,
  output logic               pc_en_o,
  output logic [1:0]         pc_src_o,
  output logic               ir_write_o,
  output logic               reg_write_o,
  output logic               reg_dst_o,
  output logic               mem_to_reg_o,
  output logic               alu_src_a_o,
  output logic [1:0]         alu_src_b_o,
  output logic [1:0]         alu_op_o,
  output logic               instr_done_o,
  output logic               illegal_op_o,
  output logic [3:0]         state_o
);

  state_t state_q, state_d;
  ctrl_t  ctrl;

  // Memory-access states only advance once the handshake completes
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = mem.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode_i)
          OP_LW, OP_SW:   state_d = S_MEM_ADDR;
          OP_ADDI:        state_d = S_ADDI_EXEC;
          OP_RTYPE:       state_d = S_R_EXEC;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_J:           state_d = S_JUMP;
          default:        state_d = S_FETCH;
        endcase
      end
      S_MEM_ADDR:  state_d = (opcode_i == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  state_d = mem.mem_ready ? S_MEM_WB : S_MEM_READ;
      S_MEM_WRITE: state_d = mem.mem_ready ? S_FETCH : S_MEM_WRITE;
      S_R_EXEC:    state_d = S_ALU_WB;
      S_ADDI_EXEC: state_d = S_ADDI_WB;
      default:     state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  mc_out_decode u_out_decode (
    .state_i     (state_q),
    .opcode_i    (opcode_i),
    .zero_i      (zero_i),
    .mem_ready_i (mem.mem_ready),
    .active_i    (rst_n),
    .ctrl_o      (ctrl)
  );

  assign mem.mem_read  = ctrl.mem_read;
  assign mem.mem_write = ctrl.mem_write;
  assign mem.iord      = ctrl.iord;
  assign pc_en_o       = ctrl.pc_en;
  assign pc_src_o      = ctrl.pc_src;
  assign ir_write_o    = ctrl.ir_write;
  assign reg_write_o   = ctrl.reg_write;
  assign reg_dst_o     = ctrl.reg_dst;
  assign mem_to_reg_o  = ctrl.mem_to_reg;
  assign alu_src_a_o   = ctrl.alu_src_a;
  assign alu_src_b_o   = ctrl.alu_src_b;
  assign alu_op_o      = ctrl.alu_op;
  assign instr_done_o  = ctrl.instr_done;
  assign illegal_op_o  = ctrl.illegal_op;
  assign state_o       = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed instructions, memory stalls,
// resets, then randomized instructions against a path-table reference model.
module tb_multicycle_ctrl;
  import mc_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic       zero;
  logic       pcEn;
  logic [1:0] pcSrc;
  logic       irWrite;
  logic       regWrite;
  logic       regDst;
  logic       memToReg;
  logic       aluSrcA;
  logic [1:0] aluSrcB;
  logic [1:0] aluOp;
  logic       instrDone;
  logic       illegalOp;
  logic [3:0] state;
  ctrl_t      dutCtrl;
  int         checks;
  int         failures;

  multicycle_ctrl_if memIf ();

  multicycle_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .opcode_i     (opcode),
    .zero_i       (zero),
    .mem          (memIf.master),
    .pc_en_o      (pcEn),
    .pc_src_o     (pcSrc),
    .ir_write_o   (irWrite),
    .reg_write_o  (regWrite),
    .reg_dst_o    (regDst),
    .mem_to_reg_o (memToReg),
    .alu_src_a_o  (aluSrcA),
    .alu_src_b_o  (aluSrcB),
    .alu_op_o     (aluOp),
    .instr_done_o (instrDone),
    .illegal_op_o (illegalOp),
    .state_o      (state)
  );

  assign dutCtrl = {pcEn, pcSrc, memIf.iord, memIf.mem_read, memIf.mem_write, irWrite,
                    regWrite, regDst, memToReg, aluSrcA, aluSrcB, aluOp, instrDone, illegalOp};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [5:0] op, input logic z, input logic rdy);
    opcode          = op;
    zero            = z;
    memIf.mem_ready = rdy;
  endtask

  function automatic bit isLegal(input logic [5:0] op);
    logic [5:0] legal [7] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                              6'b000101, 6'b000010, 6'b001000};
    foreach (legal[i]) if (legal[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  // Zero-wait latency of each instruction class
  function automatic int baseLatency(input logic [5:0] op);
    case (op)
      6'b000000: return 4;
      6'b100011: return 5;
      6'b101011: return 4;
      6'b001000: return 4;
      6'b000100, 6'b000101: return 3;
      6'b000010: return 3;
      default:   return 2;
    endcase
  endfunction

  // Expected control word for one cycle, straight from the per-state output table
  function automatic ctrl_t expCtrl(input int st, input logic [5:0] op, input logic z,
                                    input logic rdy);
    ctrl_t e;
    e = '0;
    case (st)
      0: begin e.mem_read = 1; e.alu_src_b = 2'd1; e.ir_write = rdy; e.pc_en = rdy; end
      1: begin
        e.alu_src_b = 2'd3;
        if (!isLegal(op)) begin e.illegal_op = 1; e.instr_done = 1; end
      end
      2:  begin e.alu_src_a = 1; e.alu_src_b = 2'd2; end
      3:  begin e.mem_read = 1; e.iord = 1; end
      4:  begin e.reg_write = 1; e.mem_to_reg = 1; e.instr_done = 1; end
      5:  begin e.mem_write = 1; e.iord = 1; e.instr_done = rdy; end
      6:  begin e.alu_src_a = 1; e.alu_op = 2'd2; end
      7:  begin e.reg_write = 1; e.reg_dst = 1; e.instr_done = 1; end
      8:  begin
        e.alu_src_a = 1; e.alu_op = 2'd1; e.pc_src = 2'd1; e.instr_done = 1;
        e.pc_en = (op == 6'b000101) ? !z : z;
      end
      9:  begin e.pc_src = 2'd2; e.pc_en = 1; e.instr_done = 1; end
      10: begin e.alu_src_a = 1; e.alu_src_b = 2'd2; end
      11: begin e.reg_write = 1; e.instr_done = 1; end
      default: e = '0;
    endcase
    return e;
  endfunction

  // Runs one instruction from FETCH; fWaits/mWaits are not-ready cycles in
  // FETCH and in the data access state respectively
  task automatic runInstr(input logic [5:0] op, input logic z, input int fWaits, input int mWaits);
    int   path[$];
    int   idx, waitCnt, cycles, pcEnCnt, doneCnt, doneAt, taken, waits, st;
    bit   isMem;
    logic rdy;
    case (op)
      6'b000000: path = '{0, 1, 6, 7};
      6'b100011: path = '{0, 1, 2, 3, 4};
      6'b101011: path = '{0, 1, 2, 5};
      6'b001000: path = '{0, 1, 10, 11};
      6'b000100, 6'b000101: path = '{0, 1, 8};
      6'b000010: path = '{0, 1, 9};
      default:   path = '{0, 1};
    endcase
    idx = 0; waitCnt = 0; cycles = 0; pcEnCnt = 0; doneCnt = 0; doneAt = -1;
    taken = ((op == 6'b000100) && z) || ((op == 6'b000101) && !z) || (op == 6'b000010);
    waits = fWaits + (((op == 6'b100011) || (op == 6'b101011)) ? mWaits : 0);
    for (int cyc = 0; cyc < 64 && idx < path.size(); cyc++) begin
      @(negedge clk);
      st    = path[idx];
      isMem = (st == 0) || (st == 3) || (st == 5);
      if (isMem) rdy = (waitCnt >= ((st == 0) ? fWaits : mWaits));
      else       rdy = 1'($urandom_range(0, 1));
      applyStimulus((st == 0) ? 6'($urandom) : op, (st == 8) ? z : 1'($urandom_range(0, 1)), rdy);
      #1;
      checkOutput("state", 32'(state), st);
      checkOutput("ctrl", 32'(dutCtrl), 32'(expCtrl(st, op, z, rdy)));
      pcEnCnt += int'(pcEn);
      if (instrDone) begin doneCnt++; doneAt = cycles; end
      cycles++;
      if (!isMem || rdy) begin idx++; waitCnt = 0; end
      else waitCnt++;
    end
    checkOutput("timeout", idx, path.size());
    checkOutput("doneCycle", doneAt, baseLatency(op) + waits - 1);
    checkOutput("doneCount", doneCnt, 1);
    checkOutput("pcEnCount", pcEnCnt, 1 + taken);
  endtask

  initial begin
    logic [5:0] legalOps [7] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                                 6'b000101, 6'b000010, 6'b001000};
    logic [5:0] op;
    checks   = 0;
    failures = 0;

    // Reset held with mem_ready high: no request, no enable
    rst_n = 1'b0;
    applyStimulus(6'b000000, 1'b0, 1'b1);
    repeat (2) begin
      @(posedge clk); #1;
      checkOutput("rstState", 32'(state), 0);
      checkOutput("rstCtrl", 32'(dutCtrl), 0);
    end
    rst_n = 1'b1;

    runInstr(6'b000000, 1'b0, 0, 0);
    runInstr(6'b100011, 1'b0, 0, 2);
    runInstr(6'b000100, 1'b1, 0, 0);
    runInstr(6'b000101, 1'b1, 0, 0);
    runInstr(6'b000101, 1'b0, 0, 0);
    runInstr(6'b000100, 1'b0, 1, 0);
    runInstr(6'b000010, 1'b0, 0, 0);
    runInstr(6'b101011, 1'b0, 0, 2);
    runInstr(6'b001000, 1'b0, 2, 0);
    runInstr(6'b111111, 1'b0, 0, 0);

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 8) < 7) op = legalOps[$urandom_range(0, 6)];
      else                          op = 6'($urandom);
      runInstr(op, 1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 2));
    end

    // Reset in the middle of a store that is completing this cycle
    @(negedge clk); applyStimulus(6'b101011, 1'b0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); #1;
    checkOutput("swPreRstState", 32'(state), 5);
    checkOutput("swPreRstWrite", 32'(memIf.mem_write), 1);
    rst_n = 1'b0;
    #1;
    checkOutput("midRstState", 32'(state), 0);
    checkOutput("midRstWrite", 32'(memIf.mem_write), 0);
    checkOutput("midRstCtrl", 32'(dutCtrl), 0);
    @(posedge clk); #1;
    checkOutput("midRstHoldCtrl", 32'(dutCtrl), 0);
    rst_n = 1'b1;
    runInstr(6'b000000, 1'b0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
